rfphoenix_mt_insn_queue: RTL and testbench

//  Multi-thread instruction queue between decode and issue. It holds NTHR

---
 rtl/rfphoenix_mt_insn_queue.sv | 123 ++++++++++++
 tb/tb_rfphoenix_mt_insn_queue.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rfphoenix_mt_insn_queue.sv
// Multi-thread instruction queue: NTHR independent circular FIFOs sharing one
// distributed RAM indexed {tid,ptr}, with first-word-fall-through peek and per-thread flush.
module rfphoenix_mt_insn_queue #(
  parameter int NTHR   = 4,
  parameter int DEP    = 8,
  parameter int WID    = 128,
  parameter int AFMARG = 1,
  localparam int TW    = (NTHR > 1) ? $clog2(NTHR) : 1,
  localparam int PW    = $clog2(DEP),
  localparam int CW    = $clog2(DEP + 1)
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 wr,
  input  logic [TW-1:0]        wr_tid,
  input  logic [WID-1:0]       din,
  input  logic                 rd,
  input  logic [TW-1:0]        rd_tid,
  output logic [WID-1:0]       dout,
  output logic                 v,
  input  logic [NTHR-1:0]      flush,
  output logic [NTHR*CW-1:0]   cnt,
  output logic [NTHR-1:0]      empty,
  output logic [NTHR-1:0]      full,
  output logic [NTHR-1:0]      almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  logic [WID-1:0] mem [NTHR*DEP];

  logic [PW-1:0]   rptr_q [NTHR];
  logic [PW-1:0]   rptr_d [NTHR];
  logic [PW-1:0]   wptr_q [NTHR];
  logic [PW-1:0]   wptr_d [NTHR];
  logic [CW-1:0]   cnt_q  [NTHR];
  logic [CW-1:0]   cnt_d  [NTHR];
  logic [NTHR-1:0] empty_q, empty_d;
  logic [NTHR-1:0] full_q, full_d;
  logic [NTHR-1:0] afull_q, afull_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [NTHR-1:0] push, pop;

  // Out-of-range tids never match any t, so such requests fall out silently.
  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
    for (int t = 0; t < NTHR; t++) begin
      pop[t]  = rd && (rd_tid == TW'(t)) && !empty_q[t] && !flush[t];
      push[t] = wr && (wr_tid == TW'(t)) && (!full_q[t] || pop[t]) && !flush[t];
      if (wr && (wr_tid == TW'(t)) && full_q[t] && !pop[t] && !flush[t])
        ovf_d = 1'b1;
      if (rd && (rd_tid == TW'(t)) && empty_q[t] && !flush[t])
        unf_d = 1'b1;
      if (flush[t]) begin
        rptr_d[t] = '0;
        wptr_d[t] = '0;
        cnt_d[t]  = '0;
      end else begin
        rptr_d[t] = pop[t]  ? rptr_q[t] + PW'(1) : rptr_q[t];
        wptr_d[t] = push[t] ? wptr_q[t] + PW'(1) : wptr_q[t];
        cnt_d[t]  = cnt_q[t] + CW'(push[t]) - CW'(pop[t]);
      end
      empty_d[t] = (cnt_d[t] == '0);
      full_d[t]  = (cnt_d[t] == CW'(DEP));
      afull_d[t] = (cnt_d[t] >= CW'(DEP - AFMARG));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NTHR; t++) begin
        rptr_q[t] <= '0;
        wptr_q[t] <= '0;
        cnt_q[t]  <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      afull_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        rptr_q[t] <= rptr_d[t];
        wptr_q[t] <= wptr_d[t];
        cnt_q[t]  <= cnt_d[t];
      end
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately unreset; occupancy state alone defines validity.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NTHR; t++) begin
      if (push[t]) mem[{TW'(t), wptr_q[t]}] <= din;
    end
  end

  always_comb begin
    dout = '0;
    v    = 1'b0;
    cnt  = '0;
    for (int t = 0; t < NTHR; t++) begin
      cnt[t*CW +: CW] = cnt_q[t];
      if ((rd_tid == TW'(t)) && !empty_q[t]) begin
        dout = mem[{TW'(t), rptr_q[t]}];
        v    = 1'b1;
      end
    end
  end

  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_rfphoenix_mt_insn_queue.sv
// Bench for rfphoenix_mt_insn_queue: directed scenarios then random traffic,
// compared every cycle against per-thread queues modelling the FIFO rules.
module tb_rfphoenix_mt_insn_queue;
  localparam int NTHR   = 4;
  localparam int DEP    = 8;
  localparam int WID    = 128;
  localparam int AFMARG = 1;
  localparam int TW     = 2;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr = 1'b0;
  logic [TW-1:0]     wr_tid = '0;
  logic [WID-1:0]    din = '0;
  logic              rd = 1'b0;
  logic [TW-1:0]     rd_tid = '0;
  logic [WID-1:0]    dout;
  logic              v;
  logic [NTHR-1:0]   flush = '0;
  logic [NTHR*CW-1:0] cnt;
  logic [NTHR-1:0]   empty, full, almost_full;
  logic              overflow, underflow;

  always #5 clk = ~clk;

  rfphoenix_mt_insn_queue #(.NTHR(NTHR), .DEP(DEP), .WID(WID), .AFMARG(AFMARG)) dut (
    .rst(rst), .clk(clk), .wr(wr), .wr_tid(wr_tid), .din(din), .rd(rd),
    .rd_tid(rd_tid), .dout(dout), .v(v), .flush(flush), .cnt(cnt),
    .empty(empty), .full(full), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  logic [WID-1:0] mq [NTHR][$];
  bit m_ovf, m_unf;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int rt;
    for (int t = 0; t < NTHR; t++) begin
      chk($sformatf("cnt[%0d]", t), WID'(cnt[t*CW +: CW]), WID'(mq[t].size()));
      chk($sformatf("empty[%0d]", t), WID'(empty[t]), WID'(mq[t].size() == 0));
      chk($sformatf("full[%0d]", t), WID'(full[t]), WID'(mq[t].size() == DEP));
      chk($sformatf("afull[%0d]", t), WID'(almost_full[t]), WID'(mq[t].size() >= DEP - AFMARG));
    end
    rt = int'(rd_tid);
    chk("v", WID'(v), WID'(mq[rt].size() > 0));
    chk("dout", dout, (mq[rt].size() > 0) ? mq[rt][0] : '0);
    chk("overflow", WID'(overflow), WID'(m_ovf));
    chk("underflow", WID'(underflow), WID'(m_unf));
  endtask

  // One clock: drive inputs, predict with the queue model, check after the edge.
  task automatic step(input bit w, input int wt, input logic [WID-1:0] d,
                      input bit r, input int rt, input logic [NTHR-1:0] f);
    bit p_pop, p_push;
    wr = w; wr_tid = TW'(wt); din = d; rd = r; rd_tid = TW'(rt); flush = f;
    p_pop  = r && mq[rt].size() > 0 && !f[rt];
    m_unf  = r && mq[rt].size() == 0 && !f[rt];
    p_push = w && !f[wt] && (mq[wt].size() < DEP || (p_pop && rt == wt));
    m_ovf  = w && !f[wt] && mq[wt].size() == DEP && !(p_pop && rt == wt);
    @(posedge clk);
    #1;
    for (int t = 0; t < NTHR; t++) if (f[t]) mq[t].delete();
    if (p_pop)  void'(mq[rt].pop_front());
    if (p_push) mq[wt].push_back(d);
    check_state();
  endtask

  task automatic idle(input int rt);
    step(1'b0, 0, '0, 1'b0, rt, '0);
  endtask

  function automatic logic [WID-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;
    idle(0);

    // Fill thread 2, then drain it in order
    for (int i = 0; i < 8; i++) step(1'b1, 2, WID'(8'h10 + i), 1'b0, 2, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 2, '0);
    idle(2);

    // Full thread 1: push+pop keeps it full, then overflow on push alone
    for (int i = 0; i < 8; i++) step(1'b1, 1, WID'(8'h20 + i), 1'b0, 1, '0);
    step(1'b1, 1, WID'(8'hAA), 1'b1, 1, '0);
    step(1'b1, 1, WID'(8'hBB), 1'b0, 1, '0);
    idle(1);
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 1, '0);
    idle(1);

    // Empty thread 0: push lands, pop rejected with underflow
    step(1'b1, 0, WID'(8'h55), 1'b1, 0, '0);
    idle(0);
    step(1'b0, 0, '0, 1'b1, 0, '0);

    // Flush thread 3 with a concurrent push; thread 0 keeps its entries
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, WID'(8'h30 + i), 1'b0, 3, '0);
      step(1'b1, 3, WID'(8'h40 + i), 1'b0, 3, '0);
    end
    step(1'b1, 3, WID'(8'h99), 1'b1, 3, 4'b1000);
    idle(3);
    idle(0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 1'b1, 0, '0);

    // Reset asserted mid-burst
    for (int i = 0; i < 10; i++) step(1'b1, i % NTHR, rand_word(), 1'b0, 1, '0);
    #2;
    rst = 1'b1;
    #1;
    for (int t = 0; t < NTHR; t++) mq[t].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state();
    @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;
    step(1'b1, 2, WID'(8'h10), 1'b0, 2, '0);
    step(1'b0, 0, '0, 1'b1, 2, '0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 1500; i++) begin
      logic [NTHR-1:0] f;
      f = '0;
      if ($urandom_range(0, 15) == 0) f[$urandom_range(0, NTHR - 1)] = 1'b1;
      step($urandom_range(0, 9) < 6, $urandom_range(0, NTHR - 1), rand_word(),
           $urandom_range(0, 9) < 5, $urandom_range(0, NTHR - 1), f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
